accel_bus_rx: RTL and testbench
===============================

// Module: accel_bus_rx
// PURPOSE
// Accelerator-side endpoint of the CPU accelerator bus (bus_wr/bus_data/accel_en/accel_done).
// - Decodes the CPU's write-only word stream into config registers, an operand FIFO and a start command.
// - Sequences the NN engine and returns accel_done to the CPU.
// - The bus has no backpressure: every accepted word is consumed in the cycle it arrives.
// PARAMETERS
// DATA_W      16  bus / config / FIFO word width
// NCFG        6   number of config registers (header addr 0..NCFG-1)
// FIFO_DEPTH  64  operand FIFO depth (power of 2)
// LEN_W       11  stream length field width, header bits [LEN_W-1:0]
// PORTS
// clk         in   1               clock
// rst_n       in   1               async reset, active low
// bus_wr      in   1               CPU bus write strobe; one word per cycle
// bus_data    in   DATA_W          CPU bus write data
// accel_en    in   1               0: bus_wr ignored, FSM holds state
// accel_done  out  1               operation complete, level, to CPU
// cfg_regs    out  NCFG*DATA_W     config registers, reg k at [k*DATA_W +: DATA_W]
// eng_start   out  1               1-cycle start pulse to engine
// eng_done    in   1               engine finished, 1-cycle pulse
// fifo_rd     in   1               engine pops operand FIFO
// fifo_dout   out  DATA_W          FIFO head; valid while !fifo_empty
// fifo_empty  out  1               FIFO empty
// fifo_count  out  $clog2(FIFO_DEPTH)+1   FIFO occupancy
// err_ovf     out  1               sticky: stream word dropped, FIFO full
// err_busy    out  1               sticky: bus word dropped in BUSY
// BEHAVIOUR
// Header word: [15:13] = addr, [LEN_W-1:0] = len. Accepted word = bus_wr & accel_en.
// - addr < NCFG: next word is written to cfg[addr].
// - addr 6: next len words are pushed to the FIFO.
// - addr 7: start. Header bits other than addr are ignored for addr 7.
// FSM states:
// - IDLE: accepted word is a header.
//   - addr<NCFG -> CFG.
//   - addr 6: len>0 -> STREAM (remaining=len); len==0 -> stay IDLE.
//   - addr 7 -> BUSY; eng_start=1 next cycle; err_ovf and err_busy cleared.
// - CFG: next accepted word -> cfg[addr], visible next cycle -> IDLE.
// - STREAM: each accepted word is pushed and decrements remaining; remaining reaches 0 -> IDLE.
// - BUSY: accepted words are dropped and set err_busy; eng_done -> IDLE.
// accel_done:
// - Set the cycle after eng_done is sampled in BUSY.
// - Cleared on the edge that accepts the next header.
// - eng_done outside BUSY is ignored.
// FIFO:
// - Push written at the accept edge; fifo_empty falls and count updates next cycle.
// - Push when full is dropped and sets err_ovf; remaining still decrements.
// - Push and pop when full: both occur, count unchanged.
// - Pop when empty: ignored, fifo_dout holds.
// - Pointers wrap modulo FIFO_DEPTH.
// accel_en:
// - accel_en=0 freezes the FSM and drops bus words without error.
// - FIFO pops and the BUSY -> IDLE transition still occur.
// Reset (async, any state, including mid-stream or BUSY):
// - FSM=IDLE, all cfg_regs=0, FIFO empty (count=0, dout=0).
// - accel_done=0, eng_start=0, err_ovf=0, err_busy=0.
// STRUCTURE
// accel_bus_pkg: FSM state enum {IDLE,CFG,STREAM,BUSY}; ADDR_STREAM=3'd6, ADDR_START=3'd7; header field positions.
// Sub-module accel_in_fifo: synchronous FIFO, registered outputs, push/pop/full/empty/count.
// Top: FSM, length counter, cfg register array, done/error flags.
// TESTING
// 1. Config write: hdr 16'h4000 (addr2), then 16'hBEEF -> cfg[2]=BEEF the next cycle; other cfg regs stay 0; accel_done stays 0.
// 2. Stream: hdr 16'hC003, then 3 words A,B,C -> fifo_count=3; pops return A,B,C; fifo_empty=1 after the third pop; FSM back in IDLE.
// 3. Overflow, FIFO_DEPTH=4: hdr 16'hC006 + 6 words -> count=4, err_ovf=1, first 4 words retained; start hdr 16'hE000 clears err_ovf.
// 4. Start/done: 16'hE000 -> eng_start high for exactly 1 cycle; bus word while BUSY -> err_busy=1, dropped; eng_done -> accel_done=1 next cycle; next header -> accel_done=0.
// 5. Gating and boundaries: accel_en=0 with bus_wr -> no state change; hdr 16'hC000 -> stays IDLE; simultaneous push and pop when full -> count unchanged.
// 6. Reset mid-STREAM after 2 of 5 words -> all outputs return to reset values; hdr 16'hC001 + word -> normal operation.

Source files
------------

// File: rtl/accel_bus_pkg.sv
// accel_bus_pkg: shared FSM state type, header field layout and command addresses for accel_bus_rx.
package accel_bus_pkg;

    localparam int ADDR_W       = 3;
    localparam int HDR_ADDR_LSB = 13;

    typedef logic [ADDR_W-1:0] addr_t;

    localparam addr_t ADDR_STREAM = 3'd6;
    localparam addr_t ADDR_START  = 3'd7;

    typedef enum logic [1:0] {
        IDLE,
        CFG,
        STREAM,
        BUSY
    } state_e;

endpackage

// File: rtl/accel_in_fifo.sv
// accel_in_fifo: synchronous operand FIFO with registered head, occupancy and full/empty.
//   push_i/din_i : write request and data (dropped when full unless popping in the same cycle)
//   pop_i        : read request (ignored when empty; head holds)
//   dout_o       : registered head word, empty_o/full_o/count_o : occupancy status
module accel_in_fifo #(
    parameter int  DATA_W = 16,
    parameter int  DEPTH  = 64,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push_i,
    input  logic [DATA_W-1:0] din_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] dout_o,
    output logic              empty_o,
    output logic              full_o,
    output logic [AW:0]       count_o
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_q, rd_q, rd_nx;
    logic [AW:0]       cnt_q, cnt_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              push_ok, pop_ok;

    assign empty_o = cnt_q == '0;
    assign full_o  = cnt_q == (AW+1)'(DEPTH);
    assign pop_ok  = pop_i & ~empty_o;
    assign push_ok = push_i & (~full_o | pop_ok);
    assign rd_nx   = rd_q + 1'b1;
    assign cnt_d   = cnt_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);

    // The head is kept in a register: after a pop it becomes the next stored word,
    // or the word being pushed when the FIFO drains to that word in the same cycle.
    always_comb begin
        dout_d = dout_q;
        if (pop_ok)
            dout_d = (cnt_q > (AW+1)'(1)) ? mem[rd_nx] : (push_ok ? din_i : dout_q);
        else if (empty_o && push_ok)
            dout_d = din_i;
    end

    always_ff @(posedge clk)
        if (push_ok)
            mem[wr_q] <= din_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q   <= '0;
            rd_q   <= '0;
            cnt_q  <= '0;
            dout_q <= '0;
        end else begin
            wr_q   <= push_ok ? wr_q + 1'b1 : wr_q;
            rd_q   <= pop_ok ? rd_nx : rd_q;
            cnt_q  <= cnt_d;
            dout_q <= dout_d;
        end
    end

    assign dout_o  = dout_q;
    assign count_o = cnt_q;

endmodule

// File: rtl/accel_bus_rx.sv
// accel_bus_rx: accelerator endpoint decoding the CPU write-only bus into config, operand FIFO and start.
//   bus_wr/bus_data/accel_en : CPU word stream (accepted = bus_wr & accel_en)
//   accel_done               : level, set after engine completes, cleared by next header
//   cfg_regs                 : NCFG config words, reg k at [k*DATA_W +: DATA_W]
//   eng_start/eng_done       : engine handshake pulses
//   fifo_rd/fifo_dout/fifo_empty/fifo_count : engine side of the operand FIFO
//   err_ovf/err_busy         : sticky drop flags, cleared by a start command
module accel_bus_rx
    import accel_bus_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int NCFG       = 6,
    parameter int FIFO_DEPTH = 64,
    parameter int LEN_W      = 11
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       bus_wr,
    input  logic [DATA_W-1:0]          bus_data,
    input  logic                       accel_en,
    output logic                       accel_done,
    output logic [NCFG*DATA_W-1:0]     cfg_regs,
    output logic                       eng_start,
    input  logic                       eng_done,
    input  logic                       fifo_rd,
    output logic [DATA_W-1:0]          fifo_dout,
    output logic                       fifo_empty,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                       err_ovf,
    output logic                       err_busy
);

    localparam addr_t NCFG_A = ADDR_W'(NCFG);

    state_e                         state_q, state_d;
    logic   [LEN_W-1:0]             rem_q, rem_d;
    addr_t                          cfg_addr_q, cfg_addr_d;
    logic   [NCFG-1:0][DATA_W-1:0]  cfg_q;
    logic                           done_q, start_q, ovf_q, busy_q;
    logic                           acc, hdr, push, cfg_we, start, drop_busy, fifo_full;
    addr_t                          addr;
    logic   [LEN_W-1:0]             len;

    assign acc  = bus_wr & accel_en;
    assign addr = bus_data[HDR_ADDR_LSB +: ADDR_W];
    assign len  = bus_data[LEN_W-1:0];

    always_comb begin
        state_d    = state_q;
        rem_d      = rem_q;
        cfg_addr_d = cfg_addr_q;
        hdr        = 1'b0;
        push       = 1'b0;
        cfg_we     = 1'b0;
        start      = 1'b0;
        drop_busy  = 1'b0;
        unique case (state_q)
            IDLE: if (acc) begin
                hdr = 1'b1;
                if (addr < NCFG_A) begin
                    state_d    = CFG;
                    cfg_addr_d = addr;
                end else if (addr == ADDR_STREAM) begin
                    if (len != '0) begin
                        state_d = STREAM;
                        rem_d   = len;
                    end
                end else if (addr == ADDR_START) begin
                    state_d = BUSY;
                    start   = 1'b1;
                end
            end
            CFG: if (acc) begin
                cfg_we  = 1'b1;
                state_d = IDLE;
            end
            // Words dropped on overflow still count against the stream length.
            STREAM: if (acc) begin
                push    = 1'b1;
                rem_d   = rem_q - 1'b1;
                state_d = (rem_q == LEN_W'(1)) ? IDLE : STREAM;
            end
            // Completion is honoured even while the bus is gated off.
            BUSY: begin
                drop_busy = acc;
                state_d   = eng_done ? IDLE : BUSY;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rem_q      <= '0;
            cfg_addr_q <= '0;
            cfg_q      <= '0;
            done_q     <= 1'b0;
            start_q    <= 1'b0;
            ovf_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rem_q      <= rem_d;
            cfg_addr_q <= cfg_addr_d;
            for (int k = 0; k < NCFG; k++)
                if (cfg_we && cfg_addr_q == ADDR_W'(k))
                    cfg_q[k] <= bus_data;
            done_q  <= hdr ? 1'b0 : ((state_q == BUSY && eng_done) ? 1'b1 : done_q);
            start_q <= start;
            ovf_q   <= start ? 1'b0 : ((push && fifo_full && !fifo_rd) ? 1'b1 : ovf_q);
            busy_q  <= start ? 1'b0 : (drop_busy ? 1'b1 : busy_q);
        end
    end

    accel_in_fifo #(
        .DATA_W(DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .push_i (push),
        .din_i  (bus_data),
        .pop_i  (fifo_rd),
        .dout_o (fifo_dout),
        .empty_o(fifo_empty),
        .full_o (fifo_full),
        .count_o(fifo_count)
    );

    assign accel_done = done_q;
    assign cfg_regs   = cfg_q;
    assign eng_start  = start_q;
    assign err_ovf    = ovf_q;
    assign err_busy   = busy_q;

endmodule

// File: tb/tb_accel_bus_rx.sv
// tb_accel_bus_rx: table-driven directed checks of accel_bus_rx with a 4-deep FIFO, plus reset sequences.
module tb_accel_bus_rx;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        bus_wr, accel_en, eng_done, fifo_rd;
    logic [15:0] bus_data;
    logic        accel_done, eng_start, fifo_empty, err_ovf, err_busy;
    logic [95:0] cfg_regs;
    logic [15:0] fifo_dout;
    logic [2:0]  fifo_count;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        wr, en, dn, rd;
        logic [15:0] data;
        logic        e_done, e_start, e_empty;
        logic [2:0]  e_cnt;
        logic [15:0] e_dout;
        logic        e_ovf, e_busy;
        logic [15:0] e_cfg2;
    } vec_t;

    vec_t tbl[$];

    accel_bus_rx #(
        .DATA_W(16), .NCFG(6), .FIFO_DEPTH(4), .LEN_W(11)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus_wr    (bus_wr),
        .bus_data  (bus_data),
        .accel_en  (accel_en),
        .accel_done(accel_done),
        .cfg_regs  (cfg_regs),
        .eng_start (eng_start),
        .eng_done  (eng_done),
        .fifo_rd   (fifo_rd),
        .fifo_dout (fifo_dout),
        .fifo_empty(fifo_empty),
        .fifo_count(fifo_count),
        .err_ovf   (err_ovf),
        .err_busy  (err_busy)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic wr, en, dn, rd, input logic [15:0] data,
                                input logic e_done, e_start, e_empty, input logic [2:0] e_cnt,
                                input logic [15:0] e_dout, input logic e_ovf, e_busy,
                                input logic [15:0] e_cfg2);
        vec_t v;
        v.wr = wr; v.en = en; v.dn = dn; v.rd = rd; v.data = data;
        v.e_done = e_done; v.e_start = e_start; v.e_empty = e_empty; v.e_cnt = e_cnt;
        v.e_dout = e_dout; v.e_ovf = e_ovf; v.e_busy = e_busy; v.e_cfg2 = e_cfg2;
        return v;
    endfunction

    task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic wr, en, dn, rd, input logic [15:0] d);
        bus_wr = wr; accel_en = en; eng_done = dn; fifo_rd = rd; bus_data = d;
        @(posedge clk);
        #1;
        bus_wr = 1'b0; eng_done = 1'b0; fifo_rd = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, ".done"},  16'(accel_done), 16'h0);
        check({tag, ".start"}, 16'(eng_start),  16'h0);
        check({tag, ".empty"}, 16'(fifo_empty), 16'h1);
        check({tag, ".cnt"},   16'(fifo_count), 16'h0);
        check({tag, ".dout"},  fifo_dout,       16'h0);
        check({tag, ".ovf"},   16'(err_ovf),    16'h0);
        check({tag, ".busy"},  16'(err_busy),   16'h0);
        for (int k = 0; k < 6; k++)
            check($sformatf("%s.cfg%0d", tag, k), cfg_regs[k*16 +: 16], 16'h0);
    endtask

    initial begin
        //             wr en dn rd data      done st emp cnt dout     ovf busy cfg2
        tbl.push_back(mk(1, 1, 0, 0, 16'h4000, 0, 0, 1, 0, 16'h0000, 0, 0, 16'h0000));
        tbl.push_back(mk(1, 1, 0, 0, 16'hBEEF, 0, 0, 1, 0, 16'h0000, 0, 0, 16'hBEEF));
        tbl.push_back(mk(1, 1, 0, 0, 16'hC003, 0, 0, 1, 0, 16'h0000, 0, 0, 16'hBEEF));
        tbl.push_back(mk(1, 1, 0, 0, 16'h000A, 0, 0, 0, 1, 16'h000A, 0, 0, 16'hBEEF));
        tbl.push_back(mk(1, 1, 0, 0, 16'h000B, 0, 0, 0, 2, 16'h000A, 0, 0, 16'hBEEF));
        tbl.push_back(mk(1, 1, 0, 0, 16'h000C, 0, 0, 0, 3, 16'h000A, 0, 0, 16'hBEEF));
        tbl.push_back(mk(0, 1, 0, 1, 16'h0000, 0, 0, 0, 2, 16'h000B, 0, 0, 16'hBEEF));
        tbl.push_back(mk(0, 1, 0, 1, 16'h0000, 0, 0, 0, 1, 16'h000C, 0, 0, 16'hBEEF));
        tbl.push_back(mk(0, 1, 0, 1, 16'h0000, 0, 0, 1, 0, 16'h000C, 0, 0, 16'hBEEF));
        tbl.push_back(mk(0, 1, 0, 1, 16'h0000, 0, 0, 1, 0, 16'h000C, 0, 0, 16'hBEEF));
        tbl.push_back(mk(1, 1, 0, 0, 16'hC006, 0, 0, 1, 0, 16'h000C, 0, 0, 16'hBEEF));
        tbl.push_back(mk(1, 1, 0, 0, 16'h1111, 0, 0, 0, 1, 16'h1111, 0, 0, 16'hBEEF));
        tbl.push_back(mk(1, 1, 0, 0, 16'h2222, 0, 0, 0, 2, 16'h1111, 0, 0, 16'hBEEF));
        tbl.push_back(mk(1, 1, 0, 0, 16'h3333, 0, 0, 0, 3, 16'h1111, 0, 0, 16'hBEEF));
        tbl.push_back(mk(1, 1, 0, 0, 16'h4444, 0, 0, 0, 4, 16'h1111, 0, 0, 16'hBEEF));
        tbl.push_back(mk(1, 1, 0, 0, 16'h5555, 0, 0, 0, 4, 16'h1111, 1, 0, 16'hBEEF));
        tbl.push_back(mk(1, 1, 0, 0, 16'h6666, 0, 0, 0, 4, 16'h1111, 1, 0, 16'hBEEF));
        tbl.push_back(mk(1, 1, 0, 0, 16'hE000, 0, 1, 0, 4, 16'h1111, 0, 0, 16'hBEEF));
        tbl.push_back(mk(0, 1, 0, 0, 16'h0000, 0, 0, 0, 4, 16'h1111, 0, 0, 16'hBEEF));
        tbl.push_back(mk(1, 1, 0, 0, 16'h1234, 0, 0, 0, 4, 16'h1111, 0, 1, 16'hBEEF));
        tbl.push_back(mk(0, 1, 1, 0, 16'h0000, 1, 0, 0, 4, 16'h1111, 0, 1, 16'hBEEF));
        tbl.push_back(mk(0, 1, 0, 0, 16'h0000, 1, 0, 0, 4, 16'h1111, 0, 1, 16'hBEEF));
        tbl.push_back(mk(1, 0, 0, 0, 16'hE000, 1, 0, 0, 4, 16'h1111, 0, 1, 16'hBEEF));
        tbl.push_back(mk(1, 1, 0, 0, 16'hC001, 0, 0, 0, 4, 16'h1111, 0, 1, 16'hBEEF));
        tbl.push_back(mk(1, 1, 0, 1, 16'h7777, 0, 0, 0, 4, 16'h2222, 0, 1, 16'hBEEF));
        tbl.push_back(mk(1, 1, 0, 0, 16'hC000, 0, 0, 0, 4, 16'h2222, 0, 1, 16'hBEEF));
        tbl.push_back(mk(1, 1, 0, 0, 16'h4000, 0, 0, 0, 4, 16'h2222, 0, 1, 16'hBEEF));
        tbl.push_back(mk(1, 1, 0, 0, 16'h1357, 0, 0, 0, 4, 16'h2222, 0, 1, 16'h1357));
        tbl.push_back(mk(0, 1, 1, 0, 16'h0000, 0, 0, 0, 4, 16'h2222, 0, 1, 16'h1357));
        tbl.push_back(mk(0, 1, 0, 1, 16'h0000, 0, 0, 0, 3, 16'h3333, 0, 1, 16'h1357));
        tbl.push_back(mk(0, 1, 0, 1, 16'h0000, 0, 0, 0, 2, 16'h4444, 0, 1, 16'h1357));
        tbl.push_back(mk(0, 1, 0, 1, 16'h0000, 0, 0, 0, 1, 16'h7777, 0, 1, 16'h1357));
        tbl.push_back(mk(0, 1, 0, 1, 16'h0000, 0, 0, 1, 0, 16'h7777, 0, 1, 16'h1357));
        tbl.push_back(mk(1, 1, 0, 0, 16'hE000, 0, 1, 1, 0, 16'h7777, 0, 0, 16'h1357));
        tbl.push_back(mk(1, 0, 1, 0, 16'hFFFF, 1, 0, 1, 0, 16'h7777, 0, 0, 16'h1357));
        tbl.push_back(mk(1, 1, 0, 0, 16'h0000, 0, 0, 1, 0, 16'h7777, 0, 0, 16'h1357));
        tbl.push_back(mk(1, 1, 0, 0, 16'h00AA, 0, 0, 1, 0, 16'h7777, 0, 0, 16'h1357));

        rst_n = 1'b0;
        bus_wr = 1'b0; accel_en = 1'b1; eng_done = 1'b0; fifo_rd = 1'b0; bus_data = '0;
        #12;
        check_reset_state("por");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        foreach (tbl[i]) begin
            drive(tbl[i].wr, tbl[i].en, tbl[i].dn, tbl[i].rd, tbl[i].data);
            check($sformatf("v%0d.done", i),  16'(accel_done), 16'(tbl[i].e_done));
            check($sformatf("v%0d.start", i), 16'(eng_start),  16'(tbl[i].e_start));
            check($sformatf("v%0d.empty", i), 16'(fifo_empty), 16'(tbl[i].e_empty));
            check($sformatf("v%0d.cnt", i),   16'(fifo_count), 16'(tbl[i].e_cnt));
            check($sformatf("v%0d.dout", i),  fifo_dout,       tbl[i].e_dout);
            check($sformatf("v%0d.ovf", i),   16'(err_ovf),    16'(tbl[i].e_ovf));
            check($sformatf("v%0d.busy", i),  16'(err_busy),   16'(tbl[i].e_busy));
            check($sformatf("v%0d.cfg2", i),  cfg_regs[47:32], tbl[i].e_cfg2);
        end

        check("cfg0_written", cfg_regs[15:0], 16'h00AA);
        for (int k = 1; k < 6; k++)
            if (k != 2)
                check($sformatf("cfg%0d_idle", k), cfg_regs[k*16 +: 16], 16'h0);

        // Reset asserted asynchronously mid-stream, after 2 of 5 words.
        drive(1, 1, 0, 0, 16'hC005);
        drive(1, 1, 0, 0, 16'h0101);
        drive(1, 1, 0, 0, 16'h0202);
        check("pre_rst.cnt",  16'(fifo_count), 16'h2);
        check("pre_rst.dout", fifo_dout,       16'h0101);
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_state("mid_rst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(1, 1, 0, 0, 16'hC001);
        check("post_rst.hdr_cnt", 16'(fifo_count), 16'h0);
        drive(1, 1, 0, 0, 16'h0ABC);
        check("post_rst.cnt",   16'(fifo_count), 16'h1);
        check("post_rst.dout",  fifo_dout,       16'h0ABC);
        check("post_rst.empty", 16'(fifo_empty), 16'h0);
        drive(1, 1, 0, 1, 16'h4000);
        check("post_rst.pop",   16'(fifo_empty), 16'h1);
        drive(1, 1, 0, 0, 16'h5A5A);
        check("post_rst.cfg2",  cfg_regs[47:32], 16'h5A5A);

        // Reset asserted while BUSY with eng_start high.
        drive(1, 1, 0, 0, 16'hE000);
        check("busy.start", 16'(eng_start), 16'h1);
        drive(1, 1, 0, 0, 16'h0001);
        check("busy.err", 16'(err_busy), 16'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_state("busy_rst");
        #4;
        rst_n = 1'b1;
        drive(0, 1, 1, 0, 16'h0000);
        check("busy_rst.done_ignored", 16'(accel_done), 16'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
